// File: rtl/nco_period_meter_if.sv
// Result handshake between the period meter and its consumer.
// The meter drives the result fields; the consumer drives meas_ready.
interface nco_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             timeout;
  logic             overrun;

  modport master (
    output meas_valid, period, high_time, timeout, overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, period, high_time, timeout, overrun,
    output meas_ready
  );
endinterface

// File: rtl/nco_period_meter.sv
// Measures period and high time of the NCO output in clk cycles and
// reports each result over a valid/ready handshake, with timeout and overrun flags.
module nco_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sig_in,
  nco_period_meter_if.master m
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             to;
  } res_t;

  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic             sig_d, rise;
  logic [CNT_W-1:0] wait_cnt, wait_nx;
  logic [CNT_W-1:0] pcnt, pcnt_nx;
  logic [CNT_W-1:0] hcnt, hcnt_nx;
  logic             emit;
  res_t             emit_res, res_q;
  logic             vld_q, ovr_q;

  // sig_d runs in every state so enabling while high is not seen as an edge
  assign rise = sig_in & ~sig_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    pcnt_nx  = pcnt;
    hcnt_nx  = hcnt;
    emit     = 1'b0;
    emit_res = '0;
    if (!en) begin
      state_nx = IDLE;
      wait_nx  = '0;
      pcnt_nx  = '0;
      hcnt_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ARM;
          wait_nx  = '0;
          pcnt_nx  = '0;
          hcnt_nx  = '0;
        end
        ARM: begin
          if (rise) begin
            state_nx = MEAS;
            wait_nx  = '0;
            pcnt_nx  = CNT_W'(1);
            hcnt_nx  = CNT_W'(1);
          end else if (wait_cnt == TO_M1) begin
            emit     = 1'b1;
            emit_res = '{period: TO, high: '0, to: 1'b1};
            wait_nx  = '0;
          end else begin
            wait_nx  = wait_cnt + CNT_W'(1);
          end
        end
        MEAS: begin
          if (rise) begin
            emit     = 1'b1;
            emit_res = '{period: pcnt, high: hcnt, to: 1'b0};
            pcnt_nx  = CNT_W'(1);
            hcnt_nx  = CNT_W'(1);
          end else if (pcnt == TO) begin
            emit     = 1'b1;
            emit_res = '{period: TO, high: hcnt, to: 1'b1};
            state_nx = ARM;
            wait_nx  = '0;
            pcnt_nx  = '0;
            hcnt_nx  = '0;
          end else begin
            pcnt_nx  = pcnt + CNT_W'(1);
            hcnt_nx  = hcnt + CNT_W'(sig_in);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d    <= 1'b0;
      wait_cnt <= '0;
      pcnt     <= '0;
      hcnt     <= '0;
      res_q    <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sig_d    <= sig_in;
      wait_cnt <= wait_nx;
      pcnt     <= pcnt_nx;
      hcnt     <= hcnt_nx;
      // a new result may replace the held one only if that one leaves this cycle
      if (emit && (!vld_q || m.meas_ready)) begin
        res_q <= emit_res;
        vld_q <= 1'b1;
      end else if (vld_q && m.meas_ready) begin
        vld_q <= 1'b0;
      end
      if (!en)                                  ovr_q <= 1'b0;
      else if (emit && vld_q && !m.meas_ready)  ovr_q <= 1'b1;
    end
  end

  assign m.meas_valid = vld_q;
  assign m.period     = res_q.period;
  assign m.high_time  = res_q.high;
  assign m.timeout    = res_q.to;
  assign m.overrun    = ovr_q;

endmodule

// File: tb/tb_nco_period_meter.sv
// Directed bench for nco_period_meter: waveform-derived expected results go
// into a scoreboard and are checked as the consumer accepts them.
module tb_nco_period_meter;
  localparam int CNT_W = 16;
  localparam int TO    = 20;

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
    logic             t;
  } res_t;

  logic clk, rst, en, sig_in;
  nco_period_meter_if #(.CNT_W(CNT_W)) ifc ();

  nco_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sig_in (sig_in),
    .m      (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  // waveform model: counts cycles between rising edges of the driven signal
  logic             prev = 1'b0;
  logic             seen = 1'b0;
  logic             manual = 1'b0;
  logic             last_close = 1'b0;
  logic [CNT_W-1:0] cp = '0;
  logic [CNT_W-1:0] ch = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s);
    sig_in     = s;
    last_close = 1'b0;
    if (s && !prev) begin
      if (seen) begin
        last_close = 1'b1;
        if (!manual) sb.push_back('{cp, ch, 1'b0});
      end
      cp   = 1;
      ch   = 1;
      seen = 1'b1;
    end else if (seen) begin
      cp = cp + 1;
      ch = ch + CNT_W'(s);
    end
    prev = s;
    cyc();
  endtask

  task automatic wave(input int hi, input int lo, input int n, input logic chk_vld);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi + lo; j++) begin
        step(j < hi);
        if (chk_vld) chk("vld_timing", ifc.meas_valid, last_close);
      end
    end
  endtask

  // accepted results are compared against the scoreboard head
  always @(negedge clk) begin
    res_t got, exp;
    if (!rst && ifc.meas_valid && ifc.meas_ready) begin
      got = {ifc.period, ifc.high_time, ifc.timeout};
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%h expected=none", got);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        assert (got === exp) else begin
          errors++;
          $error("FAIL result observed=%h expected=%h", got, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; ifc.meas_ready = 1'b1;
    cyc(); cyc();
    chk("rst_valid",   ifc.meas_valid, 0);
    chk("rst_period",  ifc.period,     0);
    chk("rst_high",    ifc.high_time,  0);
    chk("rst_timeout", ifc.timeout,    0);
    chk("rst_overrun", ifc.overrun,    0);
    rst = 1'b0;

    // divide-by-2, then divide-by-8 with exact valid timing
    en = 1'b1; step(0); step(0);
    wave(1, 1, 8, 1'b0);
    chk("div2_overrun", ifc.overrun, 0);
    wave(4, 4, 4, 1'b1);

    // 3 high / 7 low, then 1 high / 1 low mid-run
    wave(3, 7, 3, 1'b0);
    wave(1, 1, 4, 1'b0);
    step(0); step(0);
    en = 1'b0; step(0);
    seen = 1'b0;
    chk("sb_drain1", sb.size(), 0);

    // sig stuck low: timeout result every TO cycles from ARM
    en = 1'b1;
    for (int i = 1; i <= 62; i++) begin
      if (i == 21 || i == 41 || i == 61) sb.push_back('{CNT_W'(TO), '0, 1'b1});
      step(0);
      chk("arm_to_vld", ifc.meas_valid, (i == 21 || i == 41 || i == 61));
    end

    // stuck high after one rise: MEAS timeout with full high time
    manual = 1'b1;
    step(1);
    sb.push_back('{CNT_W'(TO), CNT_W'(TO), 1'b1});
    for (int j = 1; j <= 21; j++) begin
      step(1);
      chk("meas_to_vld", ifc.meas_valid, (j == 20));
    end
    en = 1'b0; step(0);
    seen = 1'b0;
    chk("sb_drain2", sb.size(), 0);

    // backpressure: first result held, later ones dropped
    ifc.meas_ready = 1'b0;
    en = 1'b1; step(0); step(0);
    sb.push_back('{CNT_W'(4), CNT_W'(2), 1'b0});
    wave(2, 2, 4, 1'b0);
    chk("bp_valid",   ifc.meas_valid, 1);
    chk("bp_period",  ifc.period,     4);
    chk("bp_high",    ifc.high_time,  2);
    chk("bp_timeout", ifc.timeout,    0);
    chk("bp_overrun", ifc.overrun,    1);
    ifc.meas_ready = 1'b1;
    step(0);
    chk("bp_accept_vld", ifc.meas_valid, 0);
    step(0); step(0);
    chk("bp_overrun_sticky", ifc.overrun, 1);
    en = 1'b0; step(0);
    chk("bp_overrun_clr", ifc.overrun, 0);
    seen = 1'b0;
    chk("sb_drain3", sb.size(), 0);

    // reset during MEAS with a pending result and simultaneous accept
    ifc.meas_ready = 1'b0;
    en = 1'b1; step(0); step(0);
    wave(2, 2, 1, 1'b0);
    step(1);
    chk("pre_rst_valid", ifc.meas_valid, 1);
    rst = 1'b1; ifc.meas_ready = 1'b1;
    step(0);
    chk("mrst_valid",   ifc.meas_valid, 0);
    chk("mrst_period",  ifc.period,     0);
    chk("mrst_high",    ifc.high_time,  0);
    chk("mrst_timeout", ifc.timeout,    0);
    chk("mrst_overrun", ifc.overrun,    0);
    rst = 1'b0; manual = 1'b0; seen = 1'b0;
    step(0); step(0);
    wave(2, 2, 3, 1'b1);
    step(0); step(0); step(0);
    chk("sb_drain4", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nco_period_meter.md
Name: nco_period_meter

Overview:
- Downstream consumer of the NCO output `op`.
- Measures each full period and high time of the divided signal in `clk` cycles and presents every result on a valid/ready interface.
- Flags missing or stuck signals with a timeout result, and flags results dropped under backpressure as overrun.
- Used for self-check of the clock-divider path and for reporting the achieved division ratio per `sigSel` setting.

Parameters:
- CNT_W, 16: width of the period and high-time counters and result fields.
- TIMEOUT, 65535: cycle count at which a measurement is abandoned and a timeout result is emitted. Legal range 2 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  measurement enable; 0 holds the block idle.
- sig_in  in  1  signal under measurement (NCO `op`), synchronous to `clk`.
- meas_valid  out  1  result register holds an unaccepted result.
- meas_ready  in  1  consumer accepts the result when `meas_valid` and `meas_ready` are both 1.
- period  out  CNT_W  measured period in `clk` cycles (rising edge to rising edge).
- high_time  out  CNT_W  cycles `sig_in` was 1 within that period.
- timeout  out  1  qualifies the current result as a timeout result.
- overrun  out  1  sticky flag: at least one result was dropped.

Behaviour:
- Edge detect:
  - `sig_d` <= `sig_in` every cycle, in all states, reset to 0.
  - `rise` = `sig_in` & ~`sig_d`.
- Reset values:
  - state IDLE; all counters 0.
  - `meas_valid`=0, `period`=0, `high_time`=0, `timeout`=0, `overrun`=0.
- States:
  - IDLE: counters held at 0. `en`=1 moves to ARM next cycle.
  - ARM: waiting for the first rising edge.
    - `wait_cnt` increments each cycle.
    - On `rise`: go to MEAS, `period_cnt`=1, `high_cnt`=1.
    - If `wait_cnt` reaches TIMEOUT-1 with no `rise`: emit a timeout result (`period`=TIMEOUT, `high_time`=0, `timeout`=1), clear `wait_cnt`, stay in ARM.
  - MEAS, cycle without `rise`:
    - `period_cnt`+=1.
    - `high_cnt`+=`sig_in`.
  - MEAS, cycle with `rise`:
    - Emit a result with `period`=`period_cnt`, `high_time`=`high_cnt`, `timeout`=0.
    - Reload `period_cnt`=1, `high_cnt`=1; stay in MEAS.
  - MEAS timeout: if `period_cnt` = TIMEOUT and there is no `rise`, emit a timeout result (`period`=TIMEOUT, `high_time`=`high_cnt`, `timeout`=1) and go to ARM with `wait_cnt`=0.
  - `en`=0 in any state: go to IDLE next cycle and discard the partial measurement. Result register and `meas_valid` are unaffected.
- Counter arithmetic:
  - Counters never wrap; TIMEOUT ≤ 2^CNT_W-1 guarantees this.
  - `high_cnt` ≤ `period_cnt` always.
- Result emission:
  - An emitted result is written to the output register when `meas_valid`=0, or when `meas_valid` & `meas_ready` in that same cycle.
  - `meas_valid`=1 from the next cycle. Latency: closing `rise` sampled at cycle t → result visible at t+1.
  - Otherwise the new result is dropped, the old result is held unchanged, and `overrun` is set to 1.
- Handshake:
  - `period`, `high_time` and `timeout` are stable while `meas_valid`=1 and not accepted.
  - On accept with no simultaneous emission, `meas_valid`=0 next cycle.
  - Accept and emission in the same cycle: new result loaded, `meas_valid` stays 1.
- `overrun` is cleared only by `rst`, or by a cycle with `en`=0.
- Mid-operation `rst` overrides everything, including a pending result and simultaneous accept/emission.
- Enabling while `sig_in`=1 does not count as an edge; the first measurement starts at the next true rising edge.

Test Plan:
- Divide-by-2: `sig_in` toggles every cycle, `en`=1, `meas_ready`=1 → after the second rising edge, results every 2 cycles with `period`=2, `high_time`=1, `timeout`=0, `overrun`=0.
- Divide-by-8, 50% duty (4 high / 4 low), `meas_ready`=1 → each result `period`=8, `high_time`=4; `meas_valid` rises exactly one cycle after each closing rising edge.
- Duty pattern 3 high / 7 low → `period`=10, `high_time`=3; change to 1 high / 1 low mid-run → first post-change result reflects the mixed period, later results `period`=2, `high_time`=1.
- TIMEOUT=20 override, `sig_in` held 0, `en`=1 → timeout results every 20 cycles in ARM with `period`=20, `high_time`=0, `timeout`=1. `sig_in` stuck at 1 after one rise → timeout result with `period`=20, `high_time`=20.
- Backpressure: divide-by-4, `meas_ready`=0 for 12 cycles → first result (`period`=4) held stable, later results dropped, `overrun`=1. Then `meas_ready`=1 → held result accepted; `overrun` stays 1 until `en` drops for one cycle.
- `rst` asserted during MEAS with `meas_valid`=1 → next cycle all outputs 0 and state IDLE. After release, no result appears until two rising edges have been seen.
